// File: rtl/multdiv.sv
// rtl/multdiv.sv - 32-bit signed iterative multiplier/divider with fixed 32-cycle latency
module multdiv (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t      state;
    logic [5:0]  count;
    // Shared work register: multiply keeps {partial product, multiplier},
    // divide keeps {partial remainder, dividend/quotient bits}.
    logic [63:0] acc;
    logic [31:0] mag_b;
    logic        neg;
    logic        div_zero;
    logic        div_ovf;

    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [63:0] mul_prod;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] div_next;
    logic [31:0] quot;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

    // One shift-add multiply step and one restoring divide step, plus sign fix-up of the final values
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_b} : 33'd0);
        mul_next = {mul_sum, acc[31:1]};
        // Remainder stays below the divisor, so the 32-bit difference is exact whenever div_ge holds
        div_ge   = acc[63:31] >= {1'b0, mag_b};
        div_diff = acc[62:31] - mag_b;
        div_next = div_ge ? {div_diff, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
        mul_prod = neg ? (64'd0 - mul_next) : mul_next;
        quot     = neg ? (32'd0 - div_next[31:0]) : div_next[31:0];
    end

    // Control FSM, iteration counter, datapath and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            count          <= 6'd0;
            acc            <= 64'd0;
            mag_b          <= 32'd0;
            neg            <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_MULT || ctrl_DIV) begin
                // A start pulse always wins: it begins from idle/done or aborts a running operation
                state    <= ctrl_MULT ? MULT : DIV;
                count    <= 6'd0;
                acc      <= {32'd0, abs32(data_operandA)};
                mag_b    <= abs32(data_operandB);
                neg      <= data_operandA[31] ^ data_operandB[31];
                div_zero <= (data_operandB == 32'd0);
                div_ovf  <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
            end else begin
                case (state)
                    MULT: begin
                        acc   <= mul_next;
                        count <= count + 6'd1;
                        if (count == 6'd31) begin
                            state          <= DONE;
                            data_result    <= mul_prod[31:0];
                            data_exception <= !((&mul_prod[63:31]) || !(|mul_prod[63:31]));
                            data_resultRDY <= 1'b1;
                        end
                    end
                    DIV: begin
                        acc   <= div_next;
                        count <= count + 6'd1;
                        if (count == 6'd31) begin
                            state          <= DONE;
                            data_resultRDY <= 1'b1;
                            if (div_zero) begin
                                data_result    <= 32'd0;
                                data_exception <= 1'b1;
                            end else if (div_ovf) begin
                                data_result    <= 32'h8000_0000;
                                data_exception <= 1'b1;
                            end else begin
                                data_result    <= quot;
                                data_exception <= 1'b0;
                            end
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
